// File: rtl/booth_pkg.sv
// booth_pkg: shared state encoding and default width for the booth arithmetic blocks
package booth_pkg;
  localparam int W_DEF = 4;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t FIX  = 2'd2;
endpackage

// File: rtl/booth_divider_div_step.sv
// div_step: one restoring division step (shift in next dividend bit, trial subtract, restore)
module div_step #(
  parameter int W = 4
) (
  input  logic [W:0]   pr,
  input  logic         bit_in,
  input  logic [W-1:0] dmag,
  output logic [W:0]   pr_nxt,
  output logic         q_bit
);
  logic [W+2:0] diff;
  always_comb begin
    diff   = {1'b0, pr, bit_in} - {3'b000, dmag};
    q_bit  = ~diff[W+2];
    pr_nxt = q_bit ? diff[W:0] : {pr[W-1:0], bit_in};
  end
endmodule

// File: rtl/booth_divider.sv
// booth_divider: sequential signed 2W/W restoring divider with start/done handshake
module booth_divider
  import booth_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);
  localparam int CW = $clog2(2*W) + 1;
  state_t         state;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] dvd;
  logic [W-1:0]   dmag;
  logic [W:0]     pr, pr_nxt;
  logic           sn_d, sn_v, pend, qb, ovf;
  logic [2*W-1:0] q_s;
  logic [W-1:0]   r_s;
  div_step #(.W(W)) u_step (
    .pr    (pr),
    .bit_in(dvd[2*W-1]),
    .dmag  (dmag),
    .pr_nxt(pr_nxt),
    .q_bit (qb)
  );
  // dvd doubles as the quotient shift register during CALC
  always_comb begin
    q_s  = (sn_d ^ sn_v) ? -dvd : dvd;
    r_s  = sn_d ? -pr[W-1:0] : pr[W-1:0];
    ovf  = ~(&q_s[2*W-1:W-1] | ~|q_s[2*W-1:W-1]);
    busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dmag        <= '0;
      pr          <= '0;
      sn_d        <= 1'b0;
      sn_v        <= 1'b0;
      pend        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (pend) begin
          pend        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= 1'b1;
          overflow    <= 1'b0;
          quotient    <= '1;
          remainder   <= dvd[W-1:0];
        end else if (start) begin
          sn_d        <= dividend[2*W-1];
          sn_v        <= divisor[W-1];
          dvd         <= (divisor == '0 || !dividend[2*W-1]) ? dividend : -dividend;
          dmag        <= divisor[W-1] ? -divisor : divisor;
          pr          <= '0;
          cnt         <= '0;
          div_by_zero <= 1'b0;
          overflow    <= 1'b0;
          pend        <= divisor == '0;
          state       <= (divisor == '0) ? IDLE : CALC;
        end
      end else if (state == CALC) begin
        pr    <= pr_nxt;
        dvd   <= {dvd[2*W-2:0], qb};
        cnt   <= cnt + 1'b1;
        state <= (cnt == CW'(2*W-1)) ? FIX : CALC;
      end else begin
        quotient  <= q_s[W-1:0];
        remainder <= r_s;
        overflow  <= ovf;
        done      <= 1'b1;
        state     <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_booth_divider.sv
// tb_booth_divider: directed checks of booth_divider (W=4) against hand-computed results
module tb_booth_divider;
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_by_zero, overflow;
  logic [3:0] quotient, remainder;
  int         checks = 0, errors = 0;

  booth_divider #(.W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // caller is at a negedge; poke>=0 pulses a disturbing start at that cycle
  task automatic op(input string tag, input logic [7:0] a, input logic [3:0] b, input int poke,
                    input logic [3:0] eq, input logic [3:0] er, input logic edz, input logic eov,
                    input int elat);
    int   n = 0;
    logic bz = 1'b0;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && n < 40) begin
      bz |= busy;
      if (n == poke) begin
        start = 1'b1; dividend = 8'd9; divisor = 4'd3;
      end else start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, n, elat);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dz"}, div_by_zero, edz);
    chk({tag, "_ov"}, overflow, eov);
    chk({tag, "_busy_seen"}, bz, !edz);
    chk({tag, "_busy_done"}, busy, 0);
  endtask

  initial begin
    int seen;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_flags", {div_by_zero, overflow}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    op("t1", 8'b1110_0111, 4'b0101, -1, 4'b1011, 4'b0000, 0, 0, 9);
    @(negedge clk);
    chk("t1_pulse", done, 0);
    chk("t1_hold_q", quotient, 4'b1011);
    op("t2", 8'd23, 4'b1100, -1, 4'b1011, 4'b0011, 0, 0, 9);
    @(negedge clk);
    op("t3", 8'b1110_1001, 4'd4, -1, 4'b1011, 4'b1101, 0, 0, 9);
    op("t3b2b", 8'd7, 4'd2, -1, 4'd3, 4'd1, 0, 0, 9);
    @(negedge clk);
    op("t4", 8'h5A, 4'd0, -1, 4'b1111, 4'b1010, 1, 0, 1);
    @(negedge clk);
    op("t5", 8'h80, 4'b1111, -1, 4'b0000, 4'b0000, 0, 1, 9);
    @(negedge clk);
    op("t5b", 8'd56, 4'b1000, -1, 4'b1001, 4'b0000, 0, 0, 9);
    @(negedge clk);
    op("t5c", 8'b1100_0000, 4'b1000, -1, 4'b1000, 4'b0000, 0, 1, 9);
    @(negedge clk);
    op("t6poke", 8'd50, 4'd7, 2, 4'd7, 4'd1, 0, 0, 9);
    @(negedge clk);
    dividend = 8'd50; divisor = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6rst_busy", busy, 0);
    chk("t6rst_done", done, 0);
    chk("t6rst_q", quotient, 0);
    chk("t6rst_r", remainder, 0);
    chk("t6rst_flags", {div_by_zero, overflow}, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen += done;
    end
    chk("t6rst_no_done", seen, 0);
    op("t6fresh", 8'd45, 4'd6, -1, 4'd7, 4'd3, 0, 0, 9);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
